// File: rtl/wbarb_pkg.sv
// ----------------------------------------------------------------------------
// wbarb_pkg
// Shared definitions for the register-file write-back arbiter:
//   - wb_state_e : arbiter FSM states (WB_ARB, WB_CLEAR)
//   - REG_COUNT  : number of architectural registers (r0..r31)
//   - WB_AW_DEF  : default register address width
//   - WB_DW_DEF  : default write data width
// ----------------------------------------------------------------------------
package wbarb_pkg;

    localparam int REG_COUNT = 32;
    localparam int WB_AW_DEF = 5;
    localparam int WB_DW_DEF = 32;

    typedef enum logic [0:0] {
        WB_ARB   = 1'b0,
        WB_CLEAR = 1'b1
    } wb_state_e;

endpackage : wbarb_pkg

// File: rtl/regfile_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the producer handshakes, the clear-sweep control and the register
// file write port of regfile_wb_arbiter.
//   master modport : producer / control side (drives requests, sees results)
//   slave  modport : the arbiter itself
// Signals:
//   src_valid  [NSRC]     per-source write request
//   src_ready  [NSRC]     per-source grant (transfer = valid & ready)
//   src_addr   [NSRC*AW]  packed destination registers, source i at [i*AW +: AW]
//   src_data   [NSRC*DW]  packed write data, source i at [i*DW +: DW]
//   clr_req               level request for a clear sweep of r1..r31
//   clr_busy              sweep in progress
//   rf_wr_addr/data/en    register file write port (registered)
//   grant_id   [GW]       index of the last accepted source (registered)
// ----------------------------------------------------------------------------
interface regfile_wb_arbiter_if
    import wbarb_pkg::*;
#(
    parameter int NSRC = 3,
    parameter int AW   = WB_AW_DEF,
    parameter int DW   = WB_DW_DEF,
    parameter int GW   = $clog2(NSRC)
) ();

    logic [NSRC-1:0]    src_valid;
    logic [NSRC-1:0]    src_ready;
    logic [NSRC*AW-1:0] src_addr;
    logic [NSRC*DW-1:0] src_data;
    logic               clr_req;
    logic               clr_busy;
    logic [AW-1:0]      rf_wr_addr;
    logic [DW-1:0]      rf_wr_data;
    logic               rf_wr_en;
    logic [GW-1:0]      grant_id;

    modport master (
        output src_valid, src_addr, src_data, clr_req,
        input  src_ready, clr_busy, rf_wr_addr, rf_wr_data, rf_wr_en, grant_id
    );

    modport slave (
        input  src_valid, src_addr, src_data, clr_req,
        output src_ready, clr_busy, rf_wr_addr, rf_wr_data, rf_wr_en, grant_id
    );

endinterface : regfile_wb_arbiter_if

// File: rtl/wbarb_pick.sv
// ----------------------------------------------------------------------------
// wbarb_pick
// Combinational NSRC-way priority picker. Scans the request vector starting
// at i_start and wrapping modulo NSRC; the first set bit wins.
// Ports:
//   i_req   [NSRC]  request vector
//   i_start [GW]    index searched first (0 gives fixed lowest-index priority)
//   o_grant [NSRC]  one-hot grant, all zero when nothing is requested
//   o_idx   [GW]    index of the granted request (0 when none)
//   o_any           at least one request present
// ----------------------------------------------------------------------------
module wbarb_pick #(
    parameter int NSRC = 3,
    parameter int GW   = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] i_req,
    input  logic [GW-1:0]   i_start,
    output logic [NSRC-1:0] o_grant,
    output logic [GW-1:0]   o_idx,
    output logic            o_any
);

    int w_j;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise the missing paths infer latches.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NSRC; k++) begin
            w_j = (int'(i_start) + k) % NSRC;
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = GW'(w_j);
            end
        end
    end

endmodule : wbarb_pick

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Write-back arbiter and sequencer for the single write port of the 32x32
// register file. Grants one of NSRC producers per cycle, drives the write
// port from registers one cycle after the transfer, suppresses writes to r0,
// and on clr_req runs a sweep that zeroes r1..r31 with all producers stalled.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    regfile_wb_arbiter_if.slave (handshakes, clear control, RF port)
// Configuration:
//   WBARB_RR_EN  defined   -> round-robin arbitration (pointer = last grant)
//                undefined -> fixed priority, lowest index wins
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
    import wbarb_pkg::*;
#(
    parameter int NSRC = 3,
    parameter int AW   = WB_AW_DEF,
    parameter int DW   = WB_DW_DEF,
    parameter int GW   = $clog2(NSRC)
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_wb_arbiter_if.slave bus
);

    localparam int            CW       = $clog2(REG_COUNT);
    localparam logic [CW-1:0] LAST_REG = CW'(REG_COUNT - 1);

    wb_state_e     r_state;
    wb_state_e     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic          r_wr_en;
    logic [GW-1:0] r_grant_id;

    logic [GW-1:0]   w_start;
    logic [NSRC-1:0] w_grant;
    logic [GW-1:0]   w_idx;
    logic            w_any;
    logic [NSRC-1:0] w_ready;
    logic            w_busy;
    logic            w_xfer;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

`ifdef WBARB_RR_EN
    // Pointer holds the last granted index; the search begins one past it.
    logic [GW-1:0] r_ptr;

    assign w_start = (r_ptr == GW'(NSRC - 1)) ? '0 : r_ptr + GW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= GW'(NSRC - 1);
        end else if (w_xfer) begin
            r_ptr <= w_idx;
        end
    end
`else
    assign w_start = '0;
`endif

    wbarb_pick #(
        .NSRC (NSRC),
        .GW   (GW)
    ) u_pick (
        .i_req   (bus.src_valid),
        .i_start (w_start),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Next-state and handshake decode. clr_req wins over any pending source
    // and already counts as busy in the cycle it is accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_busy      = 1'b0;
        case (r_state)
            WB_ARB: begin
                if (bus.clr_req) begin
                    w_state_nxt = WB_CLEAR;
                    w_busy      = 1'b1;
                end else begin
                    w_ready = w_grant;
                end
            end
            WB_CLEAR: begin
                w_busy = 1'b1;
                if (r_cnt == LAST_REG) begin
                    w_state_nxt = WB_ARB;
                end
            end
            default: w_state_nxt = WB_ARB;
        endcase
    end

    // Hold every producer off while reset is asserted.
    assign bus.src_ready = rst_n ? w_ready : '0;
    assign bus.clr_busy  = rst_n & w_busy;
    assign w_xfer        = |bus.src_ready;

    assign w_sel_addr = bus.src_addr[int'(w_idx) * AW +: AW];
    assign w_sel_data = bus.src_data[int'(w_idx) * DW +: DW];

    // NOTE: state registers use non-blocking assignments so every flop in
    // this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= WB_ARB;
            r_cnt      <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_en    <= 1'b0;
            r_grant_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wr_en <= 1'b0;
            case (r_state)
                WB_ARB: begin
                    if (bus.clr_req) begin
                        r_cnt <= CW'(1);
                    end else if (w_xfer) begin
                        // r0 is hard-wired zero: acknowledge but do not write.
                        r_wr_addr  <= w_sel_addr;
                        r_wr_data  <= w_sel_data;
                        r_grant_id <= w_idx;
                        r_wr_en    <= (w_sel_addr != '0);
                    end
                end
                WB_CLEAR: begin
                    r_wr_addr <= AW'(r_cnt);
                    r_wr_data <= '0;
                    r_wr_en   <= 1'b1;
                    r_cnt     <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.rf_wr_addr = r_wr_addr;
    assign bus.rf_wr_data = r_wr_data;
    assign bus.rf_wr_en   = r_wr_en;
    assign bus.grant_id   = r_grant_id;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed self-checking bench for regfile_wb_arbiter (NSRC=3, AW=5, DW=32).
// Inputs change on the falling edge; registered outputs are sampled on the
// falling edge, combinational ones 1 time unit after an input change.
// Expected grant order depends on WBARB_RR_EN.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int NSRC = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int GW   = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [AW-1:0] addr_of [NSRC] = '{5'd3, 5'd5, 5'd7};
    logic [DW-1:0] data_of [NSRC] = '{32'h0000_00A0, 32'hDEAD_BEEF, 32'h0000_0077};

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NSRC(NSRC), .AW(AW), .DW(DW), .GW(GW)) bus ();

    regfile_wb_arbiter #(.NSRC(NSRC), .AW(AW), .DW(DW), .GW(GW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.src_addr[i*AW +: AW] = a;
        bus.src_data[i*DW +: DW] = d;
    endtask

    initial begin
        int exp_seq [6];
        int busy_cnt;
        int wr_ok;
        int rdy_seen;

`ifdef WBARB_RR_EN
        exp_seq = '{0, 1, 2, 0, 1, 2};
`else
        exp_seq = '{0, 0, 0, 0, 0, 0};
`endif

        // Reset with every source requesting.
        rst_n         = 1'b0;
        bus.clr_req   = 1'b0;
        bus.src_valid = '1;
        for (int i = 0; i < NSRC; i++) set_src(i, addr_of[i], data_of[i]);
        @(negedge clk);
        step();
        #1;
        check("rst_ready", 64'(bus.src_ready), 64'(0));
        check("rst_wr_en", 64'(bus.rf_wr_en), 64'(0));
        check("rst_addr",  64'(bus.rf_wr_addr), 64'(0));
        check("rst_data",  64'(bus.rf_wr_data), 64'(0));
        check("rst_gid",   64'(bus.grant_id), 64'(0));
        check("rst_busy",  64'(bus.clr_busy), 64'(0));

        // First cycle after reset grants source 0.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_ready", 64'(bus.src_ready), 64'(3'b001));
        step();
        check("first_en",   64'(bus.rf_wr_en), 64'(1));
        check("first_addr", 64'(bus.rf_wr_addr), 64'(3));
        check("first_gid",  64'(bus.grant_id), 64'(0));
        bus.src_valid = '0;
        #1;
        check("idle_ready", 64'(bus.src_ready), 64'(0));
        step();
        check("idle_en",   64'(bus.rf_wr_en), 64'(0));
        check("idle_addr", 64'(bus.rf_wr_addr), 64'(3));
        check("idle_data", 64'(bus.rf_wr_data), 64'(32'h0000_00A0));

        // Source 1 alone: r5 <= 0xDEADBEEF, one cycle latency.
        bus.src_valid = 3'b010;
        #1;
        check("s1_ready", 64'(bus.src_ready), 64'(3'b010));
        step();
        check("s1_en",   64'(bus.rf_wr_en), 64'(1));
        check("s1_addr", 64'(bus.rf_wr_addr), 64'(5));
        check("s1_data", 64'(bus.rf_wr_data), 64'(32'hDEAD_BEEF));
        check("s1_gid",  64'(bus.grant_id), 64'(1));
        bus.src_valid = '0;
        step();
        check("s1_en_drop", 64'(bus.rf_wr_en), 64'(0));
        check("s1_hold",    64'(bus.rf_wr_data), 64'(32'hDEAD_BEEF));

        // Source 2 writes r0: acknowledged, no write enable.
        set_src(2, 5'd0, 32'h0000_1234);
        bus.src_valid = 3'b100;
        #1;
        check("r0_ready", 64'(bus.src_ready), 64'(3'b100));
        step();
        check("r0_en",   64'(bus.rf_wr_en), 64'(0));
        check("r0_gid",  64'(bus.grant_id), 64'(2));
        check("r0_data", 64'(bus.rf_wr_data), 64'(32'h0000_1234));
        set_src(2, addr_of[2], data_of[2]);

        // All sources continuously valid.
        bus.src_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("all_ready%0d", k), 64'(bus.src_ready), 64'(1 << exp_seq[k]));
            step();
            check($sformatf("all_gid%0d", k),  64'(bus.grant_id), 64'(exp_seq[k]));
            check($sformatf("all_addr%0d", k), 64'(bus.rf_wr_addr), 64'(addr_of[exp_seq[k]]));
            check($sformatf("all_en%0d", k),   64'(bus.rf_wr_en), 64'(1));
        end

        // One-cycle clr_req pulse with source 0 waiting.
        bus.src_valid = 3'b001;
        bus.clr_req   = 1'b1;
        busy_cnt      = 0;
        wr_ok         = 0;
        rdy_seen      = 0;
        #1;
        check("clr_req_ready", 64'(bus.src_ready), 64'(0));
        if (bus.clr_busy === 1'b1) busy_cnt++;
        step();
        bus.clr_req = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            #1;
            if (bus.clr_busy === 1'b1) busy_cnt++;
            if (bus.src_ready !== '0) rdy_seen++;
            step();
            if (bus.rf_wr_en === 1'b1 && bus.rf_wr_addr === AW'(k) && bus.rf_wr_data === '0)
                wr_ok++;
        end
        #1;
        check("sweep_busy_cycles", 64'(busy_cnt), 64'(32));
        check("sweep_writes",      64'(wr_ok), 64'(31));
        check("sweep_ready_seen",  64'(rdy_seen), 64'(0));
        check("sweep_busy_fall",   64'(bus.clr_busy), 64'(0));
        check("post_sweep_ready",  64'(bus.src_ready), 64'(3'b001));
        step();
        check("post_sweep_en",   64'(bus.rf_wr_en), 64'(1));
        check("post_sweep_addr", 64'(bus.rf_wr_addr), 64'(3));
        check("post_sweep_gid",  64'(bus.grant_id), 64'(0));
        bus.src_valid = '0;

        // Reset in the middle of a sweep, at write 10.
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        repeat (9) step();
        check("mid_w9_addr", 64'(bus.rf_wr_addr), 64'(9));
        check("mid_w9_en",   64'(bus.rf_wr_en), 64'(1));
        rst_n = 1'b0;
        step();
        check("mid_rst_en",   64'(bus.rf_wr_en), 64'(0));
        check("mid_rst_addr", 64'(bus.rf_wr_addr), 64'(0));
        rst_n = 1'b1;
        #1;
        check("mid_rst_busy", 64'(bus.clr_busy), 64'(0));

        // Fresh sweep restarts at r1 and runs to r31.
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        step();
        check("restart_addr", 64'(bus.rf_wr_addr), 64'(1));
        check("restart_en",   64'(bus.rf_wr_en), 64'(1));
        check("restart_busy", 64'(bus.clr_busy), 64'(1));
        repeat (30) step();
        check("restart_last_addr", 64'(bus.rf_wr_addr), 64'(31));
        #1;
        check("restart_done_busy", 64'(bus.clr_busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
